// File: rtl/fp8_accum_seq.sv
// Sequential FP8 accumulator: streams operands into an external combinational
// add/sub unit (simple_fpu) and returns one accumulated result per group.
module fp8_accum_seq #(
  parameter int unsigned FPU_LAT = 1,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_sub,
  input  logic             in_last,
  output logic [7:0]       fpu_a,
  output logic [7:0]       fpu_b,
  output logic             fpu_op,
  input  logic [7:0]       fpu_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             busy
);

  localparam int unsigned WAIT_W = 3;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state,     state_d;
  logic [7:0]        acc,       acc_d;
  logic [CNT_W-1:0]  count,     count_d;
  logic              first,     first_d;
  logic              last_q,    last_d;
  logic [WAIT_W-1:0] wait_cnt,  wait_d;
  logic [7:0]        fpu_a_d,   fpu_b_d;
  logic              fpu_op_d;
  logic              out_valid_d;
  logic [7:0]        out_data_d;
  logic [CNT_W-1:0]  out_count_d;
  logic              busy_d, in_ready_d;

  logic              accept_c;
  logic [CNT_W-1:0]  count_inc_c;
  logic [7:0]        operand_c;

  // Operand as it enters the accumulator on a first accept (sign flipped for subtract)
  always_comb begin
    accept_c    = in_valid && in_ready;
    count_inc_c = (count == {CNT_W{1'b1}}) ? count : count + CNT_W'(1);
    operand_c   = in_sub ? {~in_data[7], in_data[6:0]} : in_data;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Next-state and register-update logic
  always_comb begin
    state_d     = state;
    acc_d       = acc;
    count_d     = count;
    first_d     = first;
    last_d      = last_q;
    wait_d      = wait_cnt;
    fpu_a_d     = fpu_a;
    fpu_b_d     = fpu_b;
    fpu_op_d    = fpu_op;
    out_valid_d = out_valid;
    out_data_d  = out_data;
    out_count_d = out_count;

    case (state)
      IDLE: begin
        if (accept_c) begin
          count_d = count_inc_c;
          last_d  = in_last;
          if (first) begin
            // First operand of a group bypasses the FPU
            acc_d   = operand_c;
            first_d = 1'b0;
            if (in_last) begin
              state_d     = DONE;
              out_valid_d = 1'b1;
              out_data_d  = operand_c;
              out_count_d = count_inc_c;
            end
          end else begin
            fpu_a_d  = acc;
            fpu_b_d  = in_data;
            fpu_op_d = in_sub;
            wait_d   = '0;
            state_d  = EXEC;
          end
        end else if (clr) begin
          acc_d   = 8'h00;
          count_d = '0;
          first_d = 1'b1;
        end
      end
      EXEC: begin
        wait_d = wait_cnt + WAIT_W'(1);
        if (wait_cnt == WAIT_W'(FPU_LAT - 1)) begin
          acc_d = fpu_result;
          if (last_q) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            out_data_d  = fpu_result;
            out_count_d = count;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          acc_d       = 8'h00;
          count_d     = '0;
          first_d     = 1'b1;
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d     = (state_d != IDLE);
    in_ready_d = (state_d == IDLE);
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= 8'h00;
      count     <= '0;
      first     <= 1'b1;
      last_q    <= 1'b0;
      wait_cnt  <= '0;
      fpu_a     <= 8'h00;
      fpu_b     <= 8'h00;
      fpu_op    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      out_count <= '0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      acc       <= acc_d;
      count     <= count_d;
      first     <= first_d;
      last_q    <= last_d;
      wait_cnt  <= wait_d;
      fpu_a     <= fpu_a_d;
      fpu_b     <= fpu_b_d;
      fpu_op    <= fpu_op_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      out_count <= out_count_d;
      busy      <= busy_d;
      in_ready  <= in_ready_d;
    end
  end

endmodule

// File: tb/tb_fp8_accum_seq.sv
// Bench for fp8_accum_seq: two instances (FPU_LAT=1 and 3) share one stimulus
// stream, each wired to its own behavioural FP8 add/sub unit.
module tb_fp8_accum_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_sub;
  logic       in_last;
  logic       out_ready;

  logic       in_ready   [2];
  logic [7:0] fpu_a      [2];
  logic [7:0] fpu_b      [2];
  logic       fpu_op     [2];
  logic [7:0] fpu_result [2];
  logic       out_valid  [2];
  logic [7:0] out_data   [2];
  logic [7:0] out_count  [2];
  logic       busy       [2];

  int vectors = 0;
  int miscompares = 0;
  int lat [2] = '{1, 3};

  always #5 clk = ~clk;

  // Behavioural FP8 (1/4/3, bias 7) add/sub, truncating, subnormals as zero
  function automatic logic [7:0] fp8_add(input logic [7:0] a, input logic [7:0] b, input logic op);
    logic       sa, sb, ts;
    logic [3:0] ea, eb, te;
    logic [7:0] ma, mb, tm, mr;
    int         e;
    sa = a[7];
    sb = b[7] ^ op;
    ea = a[6:3];
    eb = b[6:3];
    ma = (ea == 4'd0) ? 8'd0 : {2'b01, a[2:0], 3'b000};
    mb = (eb == 4'd0) ? 8'd0 : {2'b01, b[2:0], 3'b000};
    if (eb > ea || (eb == ea && mb > ma)) begin
      ts = sa; sa = sb; sb = ts;
      te = ea; ea = eb; eb = te;
      tm = ma; ma = mb; mb = tm;
    end
    mb = mb >> (ea - eb);
    mr = (sa == sb) ? ma + mb : ma - mb;
    if (mr == 8'd0) return 8'h00;
    e = int'(ea);
    if (mr[7]) begin
      mr = mr >> 1;
      e++;
    end
    for (int i = 0; i < 7; i++) begin
      if (!mr[6]) begin
        mr = mr << 1;
        e--;
      end
    end
    if (e <= 0) return {sa, 7'h00};
    if (e >= 15) return {sa, 4'hF, 3'h0};
    return {sa, 4'(e), mr[5:3]};
  endfunction

  assign fpu_result[0] = fp8_add(fpu_a[0], fpu_b[0], fpu_op[0]);
  assign fpu_result[1] = fp8_add(fpu_a[1], fpu_b[1], fpu_op[1]);

  fp8_accum_seq #(.FPU_LAT(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready[0]), .in_data(in_data),
    .in_sub(in_sub), .in_last(in_last),
    .fpu_a(fpu_a[0]), .fpu_b(fpu_b[0]), .fpu_op(fpu_op[0]), .fpu_result(fpu_result[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready), .out_data(out_data[0]),
    .out_count(out_count[0]), .busy(busy[0])
  );

  fp8_accum_seq #(.FPU_LAT(3), .CNT_W(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready[1]), .in_data(in_data),
    .in_sub(in_sub), .in_last(in_last),
    .fpu_a(fpu_a[1]), .fpu_b(fpu_b[1]), .fpu_op(fpu_op[1]), .fpu_result(fpu_result[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready), .out_data(out_data[1]),
    .out_count(out_count[1]), .busy(busy[1])
  );

  // Present one operand once both instances are ready; returns half a cycle after the accept edge
  task automatic send(input logic [7:0] d, input logic s, input logic l);
    int n = 0;
    while (!(in_ready[0] && in_ready[1]) && n < 50) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (n >= 50) begin
      miscompares++;
      $display("FAIL send_timeout: in_ready=%b/%b required 1/1", in_ready[0], in_ready[1]);
    end
    in_data  = d;
    in_sub   = s;
    in_last  = l;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_sub   = 1'b0;
    in_last  = 1'b0;
  endtask

  // Wait (bounded) until both instances present a result
  task automatic wait_valid();
    int n = 0;
    while (!(out_valid[0] && out_valid[1]) && n < 20) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (n >= 20) begin
      miscompares++;
      $display("FAIL out_valid_timeout: out_valid=%b/%b required 1/1", out_valid[0], out_valid[1]);
    end
  endtask

  // One-cycle out_ready pulse
  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    in_sub = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (out_valid[k] !== 1'b0 || out_data[k] !== 8'h00 || out_count[k] !== 8'h00 ||
          busy[k] !== 1'b0 || in_ready[k] !== 1'b1 || fpu_a[k] !== 8'h00 ||
          fpu_b[k] !== 8'h00 || fpu_op[k] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset[%0d]: v=%b d=%h c=%h busy=%b rdy=%b a=%h b=%h op=%b required 0 00 00 0 1 00 00 0",
                 k, out_valid[k], out_data[k], out_count[k], busy[k], in_ready[k],
                 fpu_a[k], fpu_b[k], fpu_op[k]);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add_group();
    int seen [2] = '{0, 0};
    send(8'h3C, 1'b0, 1'b0);
    send(8'h42, 1'b0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (fpu_a[k] !== 8'h3C || fpu_b[k] !== 8'h42 || fpu_op[k] !== 1'b0 || busy[k] !== 1'b1) begin
        miscompares++;
        $display("FAIL add_fpu_drive[%0d]: a=%h b=%h op=%b busy=%b required 3c 42 0 1",
                 k, fpu_a[k], fpu_b[k], fpu_op[k], busy[k]);
      end
    end
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++)
        if (out_valid[k] && seen[k] == 0) seen[k] = n;
    end
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (seen[k] != lat[k]) begin
        miscompares++;
        $display("FAIL add_latency[%0d]: cycles=%0d required %0d", k, seen[k], lat[k]);
      end
      vectors++;
      if (out_data[k] !== 8'h48 || out_count[k] !== 8'd2 || fpu_a[k] !== 8'h3C || fpu_b[k] !== 8'h42) begin
        miscompares++;
        $display("FAIL add_result[%0d]: d=%h c=%0d a=%h b=%h required 48 2 3c 42",
                 k, out_data[k], out_count[k], fpu_a[k], fpu_b[k]);
      end
    end
    release_out();
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (out_valid[k] !== 1'b0 || in_ready[k] !== 1'b1) begin
        miscompares++;
        $display("FAIL add_release[%0d]: v=%b rdy=%b required 0 1", k, out_valid[k], in_ready[k]);
      end
    end
  endtask

  task automatic test_single_sub();
    send(8'h38, 1'b1, 1'b1);
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (out_valid[k] !== 1'b1 || out_data[k] !== 8'hB8 || out_count[k] !== 8'd1 ||
          fpu_a[k] !== 8'h3C || fpu_b[k] !== 8'h42 || fpu_op[k] !== 1'b0) begin
        miscompares++;
        $display("FAIL single_sub[%0d]: v=%b d=%h c=%0d a=%h b=%h op=%b required 1 b8 1 3c 42 0",
                 k, out_valid[k], out_data[k], out_count[k], fpu_a[k], fpu_b[k], fpu_op[k]);
      end
    end
    release_out();
  endtask

  task automatic test_cancel();
    send(8'h3C, 1'b0, 1'b0);
    send(8'h3C, 1'b1, 1'b1);
    wait_valid();
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (out_data[k] !== 8'h00 || out_count[k] !== 8'd2 || fpu_op[k] !== 1'b1 ||
          fpu_a[k] !== 8'h3C || fpu_b[k] !== 8'h3C) begin
        miscompares++;
        $display("FAIL cancel[%0d]: d=%h c=%0d a=%h b=%h op=%b required 00 2 3c 3c 1",
                 k, out_data[k], out_count[k], fpu_a[k], fpu_b[k], fpu_op[k]);
      end
    end
    release_out();
  endtask

  task automatic test_backpressure();
    send(8'h40, 1'b0, 1'b0);
    send(8'h40, 1'b0, 1'b1);
    wait_valid();
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (out_valid[k] !== 1'b1 || out_data[k] !== 8'h48 || out_count[k] !== 8'd2 ||
            in_ready[k] !== 1'b0 || busy[k] !== 1'b1) begin
          miscompares++;
          $display("FAIL backpressure[%0d] cyc%0d: v=%b d=%h c=%0d rdy=%b busy=%b required 1 48 2 0 1",
                   k, n, out_valid[k], out_data[k], out_count[k], in_ready[k], busy[k]);
        end
      end
    end
    release_out();
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (out_valid[k] !== 1'b0 || in_ready[k] !== 1'b1 || busy[k] !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_release[%0d]: v=%b rdy=%b busy=%b required 0 1 0",
                 k, out_valid[k], in_ready[k], busy[k]);
      end
    end
  endtask

  task automatic test_reset_exec();
    send(8'h3C, 1'b0, 1'b0);
    send(8'h42, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (busy[k] !== 1'b1 || in_ready[k] !== 1'b0) begin
        miscompares++;
        $display("FAIL exec_entry[%0d]: busy=%b rdy=%b required 1 0", k, busy[k], in_ready[k]);
      end
    end
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (busy[k] !== 1'b0 || in_ready[k] !== 1'b1 || out_valid[k] !== 1'b0 ||
          out_count[k] !== 8'h00 || fpu_a[k] !== 8'h00 || fpu_b[k] !== 8'h00) begin
        miscompares++;
        $display("FAIL async_reset[%0d]: busy=%b rdy=%b v=%b c=%0d a=%h b=%h required 0 1 0 0 00 00",
                 k, busy[k], in_ready[k], out_valid[k], out_count[k], fpu_a[k], fpu_b[k]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(8'h38, 1'b0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (out_valid[k] !== 1'b1 || out_data[k] !== 8'h38 || out_count[k] !== 8'd1) begin
        miscompares++;
        $display("FAIL post_reset_group[%0d]: v=%b d=%h c=%0d required 1 38 1",
                 k, out_valid[k], out_data[k], out_count[k]);
      end
    end
    release_out();
  endtask

  task automatic test_clr();
    send(8'h3C, 1'b0, 1'b0);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    send(8'h40, 1'b0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (out_valid[k] !== 1'b1 || out_data[k] !== 8'h40 || out_count[k] !== 8'd1 || fpu_a[k] !== 8'h00) begin
        miscompares++;
        $display("FAIL clr_restart[%0d]: v=%b d=%h c=%0d a=%h required 1 40 1 00",
                 k, out_valid[k], out_data[k], out_count[k], fpu_a[k]);
      end
    end
    release_out();
  endtask

  initial begin
    test_reset();
    test_add_group();
    test_single_sub();
    test_cancel();
    test_backpressure();
    test_reset_exec();
    test_clr();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
